// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP host-side blocks: the CPU port FSM state
// encoding, VRAM address geometry and control-byte field positions.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_ADDR_MAX = 14'h3FFF;

  // Second control byte: bit 7 selects a register write, bit 6 separates
  // write setup (1) from read setup (0) when bit 7 is clear.
  localparam int CTL_REG_BIT   = 7;
  localparam int CTL_WRITE_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FETCH   = 2'd2,
    ST_CAPTURE = 2'd3
  } cpu_port_state_t;

  // Auto-increment of the VRAM pointer, wrapping at the top of the 16 KB space.
  function automatic logic [VRAM_ADDR_W-1:0] vram_addr_next(input logic [VRAM_ADDR_W-1:0] a);
    return (a == VRAM_ADDR_MAX) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/vdp_cpu_port_if.sv
// Host bus between the bus synchronizer (master) and the VDP CPU port (slave).
interface vdp_cpu_port_if;

  logic       cpu_wr;
  logic       cpu_rd;
  logic       cpu_mode;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_busy;

  modport master (
    output cpu_wr, cpu_rd, cpu_mode, cpu_din,
    input  cpu_dout, cpu_busy
  );

  modport slave (
    input  cpu_wr, cpu_rd, cpu_mode, cpu_din,
    output cpu_dout, cpu_busy
  );

endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: decodes the two-port host byte protocol into VRAM writes,
// read-ahead fetches, register writes and status reads.
// Build option: define VDP_WRITE_READAHEAD_EN to have data writes also load
// the read-ahead buffer with the written byte (legacy chip behaviour).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | accepting host strobes; vram_addr shows the current pointer
// ST_WRITE   | vram_we high for one cycle, pointer increments at the end
// ST_FETCH   | pointer presented to VRAM, data returns next cycle
// ST_CAPTURE | VRAM data captured into the read-ahead buffer, pointer +1
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  vdp_cpu_port_if.slave     cpu,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout,
  output logic              reg_we,
  output logic [2:0]        reg_num,
  output logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] status_in,
  output logic              status_clr
);

  cpu_port_state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] latch_lo;
  logic              phase;
  logic [DATA_W-1:0] rab;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] wbyte;

  logic idle;
  logic acc_wr;
  logic acc_rd;
  logic ctl_reg;
  logic ctl_rd_setup;

  // Strobe qualification: only idle accepts, and a write masks a simultaneous read.
  always_comb begin
    idle         = (state == ST_IDLE);
    acc_wr       = idle & cpu.cpu_wr;
    acc_rd       = idle & cpu.cpu_rd & ~cpu.cpu_wr;
    ctl_reg      = cpu.cpu_din[CTL_REG_BIT];
    ctl_rd_setup = ~cpu.cpu_din[CTL_REG_BIT] & ~cpu.cpu_din[CTL_WRITE_BIT];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc_wr && !cpu.cpu_mode)
          state_nxt = ST_WRITE;
        else if (acc_wr && cpu.cpu_mode && phase && ctl_rd_setup)
          state_nxt = ST_FETCH;
        else if (acc_rd && !cpu.cpu_mode)
          state_nxt = ST_FETCH;
      end
      ST_WRITE:   state_nxt = ST_IDLE;
      ST_FETCH:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Protocol datapath: pointer, byte latch, read-ahead buffer and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      latch_lo   <= '0;
      phase      <= 1'b0;
      rab        <= '0;
      dout_q     <= '0;
      wbyte      <= '0;
      reg_we     <= 1'b0;
      reg_num    <= '0;
      reg_data   <= '0;
      status_clr <= 1'b0;
    end else begin
      reg_we     <= 1'b0;
      status_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_wr && cpu.cpu_mode) begin
            if (!phase) begin
              latch_lo <= cpu.cpu_din;
              phase    <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (ctl_reg) begin
                reg_we   <= 1'b1;
                reg_num  <= cpu.cpu_din[2:0];
                reg_data <= latch_lo;
              end else begin
                addr <= {cpu.cpu_din[ADDR_W-DATA_W-1:0], latch_lo};
              end
            end
          end else if (acc_wr) begin
            phase <= 1'b0;
            wbyte <= cpu.cpu_din;
          end else if (acc_rd && cpu.cpu_mode) begin
            dout_q     <= status_in;
            phase      <= 1'b0;
            status_clr <= 1'b1;
          end else if (acc_rd) begin
            phase  <= 1'b0;
            dout_q <= rab;
          end
        end
        ST_WRITE: begin
          addr <= vram_addr_next(addr);
`ifdef VDP_WRITE_READAHEAD_EN
          rab <= wbyte;
`else
          rab <= rab;
`endif
        end
        ST_CAPTURE: begin
          rab  <= vram_dout;
          addr <= vram_addr_next(addr);
        end
        default: ;
      endcase
    end
  end

  // The pointer is shown on the VRAM port in every state; the write enable
  // decodes straight from the state so reset removes it without a clock.
  always_comb begin
    vram_addr    = addr;
    vram_we      = (state == ST_WRITE);
    vram_din     = wbyte;
    cpu.cpu_dout = dout_q;
    cpu.cpu_busy = ~idle;
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

  logic       clk;
  logic       rst_n;
  logic [13:0] vram_addr;
  logic       vram_we;
  logic [7:0] vram_din;
  logic [7:0] vram_dout;
  logic       reg_we;
  logic [2:0] reg_num;
  logic [7:0] reg_data;
  logic [7:0] status_in;
  logic       status_clr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] mem [0:16383];

  vdp_cpu_port_if cpu_bus();

  vdp_cpu_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpu_bus.slave),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_din   (vram_din),
    .vram_dout  (vram_dout),
    .reg_we     (reg_we),
    .reg_num    (reg_num),
    .reg_data   (reg_data),
    .status_in  (status_in),
    .status_clr (status_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency synchronous VRAM, read-before-write.
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One-cycle strobe; returns #1 into cycle N+1.
  task automatic host_op(input logic wr, input logic rd, input logic mode, input logic [7:0] din);
    cpu_bus.cpu_wr   = wr;
    cpu_bus.cpu_rd   = rd;
    cpu_bus.cpu_mode = mode;
    cpu_bus.cpu_din  = din;
    step();
    cpu_bus.cpu_wr = 1'b0;
    cpu_bus.cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_rd = 1'b0; cpu_bus.cpu_mode = 1'b0; cpu_bus.cpu_din = 8'h00;
    status_in = 8'h00;
    repeat (3) step();
    chk_cnt++; if ({cpu_bus.cpu_dout, cpu_bus.cpu_busy} !== 9'h000) $display("FAIL reset_cpu: dout/busy=%h want 000", {cpu_bus.cpu_dout, cpu_bus.cpu_busy}); else pass_cnt++;
    chk_cnt++; if ({vram_addr, vram_we, vram_din} !== 23'h0) $display("FAIL reset_vram: addr=%h we=%b din=%h want 0", vram_addr, vram_we, vram_din); else pass_cnt++;
    chk_cnt++; if ({reg_we, reg_num, reg_data, status_clr} !== 13'h0) $display("FAIL reset_reg: we=%b num=%h data=%h clr=%b want 0", reg_we, reg_num, reg_data, status_clr); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addr_write();
    host_op(1, 0, 1, 8'h34);
    host_op(1, 0, 1, 8'h52);
    chk_cnt++; if (cpu_bus.cpu_busy !== 1'b0) $display("FAIL wsetup_nofetch: busy=%b want 0", cpu_bus.cpu_busy); else pass_cnt++;
    chk_cnt++; if (vram_addr !== 14'h1234) $display("FAIL wsetup_addr: got %h want 1234", vram_addr); else pass_cnt++;
    host_op(1, 0, 0, 8'hA5);
    chk_cnt++; if ({vram_we, vram_addr, vram_din, cpu_bus.cpu_busy} !== {1'b1, 14'h1234, 8'hA5, 1'b1}) $display("FAIL dwrite_cycle: we=%b addr=%h din=%h busy=%b want 1 1234 a5 1", vram_we, vram_addr, vram_din, cpu_bus.cpu_busy); else pass_cnt++;
    step();
    chk_cnt++; if ({vram_we, vram_addr, cpu_bus.cpu_busy} !== {1'b0, 14'h1235, 1'b0}) $display("FAIL dwrite_after: we=%b addr=%h busy=%b want 0 1235 0", vram_we, vram_addr, cpu_bus.cpu_busy); else pass_cnt++;
    chk_cnt++; if (mem[14'h1234] !== 8'hA5) $display("FAIL dwrite_mem: got %h want a5", mem[14'h1234]); else pass_cnt++;
  endtask

  task automatic test_reg_write();
    host_op(1, 0, 1, 8'h07);
    host_op(1, 0, 1, 8'h81);
    chk_cnt++; if ({reg_we, reg_num, reg_data} !== {1'b1, 3'd1, 8'h07}) $display("FAIL regw_pulse: we=%b num=%0d data=%h want 1 1 07", reg_we, reg_num, reg_data); else pass_cnt++;
    chk_cnt++; if ({vram_addr, cpu_bus.cpu_busy} !== {14'h1235, 1'b0}) $display("FAIL regw_addr: addr=%h busy=%b want 1235 0", vram_addr, cpu_bus.cpu_busy); else pass_cnt++;
    step();
    chk_cnt++; if (reg_we !== 1'b0) $display("FAIL regw_oneshot: we=%b want 0", reg_we); else pass_cnt++;
  endtask

  task automatic test_read();
    host_op(1, 0, 1, 8'h00);
    host_op(1, 0, 1, 8'h41);
    host_op(1, 0, 0, 8'h3C); step();
    host_op(1, 0, 0, 8'h5A); step();
    host_op(1, 0, 1, 8'h00);
    host_op(1, 0, 1, 8'h01);
    chk_cnt++; if ({cpu_bus.cpu_busy, vram_addr} !== {1'b1, 14'h0100}) $display("FAIL rsetup_fetch: busy=%b addr=%h want 1 0100", cpu_bus.cpu_busy, vram_addr); else pass_cnt++;
    step();
    chk_cnt++; if (cpu_bus.cpu_busy !== 1'b1) $display("FAIL rsetup_capture: busy=%b want 1", cpu_bus.cpu_busy); else pass_cnt++;
    step();
    chk_cnt++; if ({cpu_bus.cpu_busy, dut.rab, vram_addr} !== {1'b0, 8'h3C, 14'h0101}) $display("FAIL rsetup_rab: busy=%b rab=%h addr=%h want 0 3c 0101", cpu_bus.cpu_busy, dut.rab, vram_addr); else pass_cnt++;
    host_op(0, 1, 0, 8'h00);
    chk_cnt++; if ({cpu_bus.cpu_dout, cpu_bus.cpu_busy} !== {8'h3C, 1'b1}) $display("FAIL dread_dout: dout=%h busy=%b want 3c 1", cpu_bus.cpu_dout, cpu_bus.cpu_busy); else pass_cnt++;
    step(); step();
    chk_cnt++; if ({dut.rab, vram_addr, cpu_bus.cpu_dout, cpu_bus.cpu_busy} !== {8'h5A, 14'h0102, 8'h3C, 1'b0}) $display("FAIL dread_next: rab=%h addr=%h dout=%h busy=%b want 5a 0102 3c 0", dut.rab, vram_addr, cpu_bus.cpu_dout, cpu_bus.cpu_busy); else pass_cnt++;
  endtask

  task automatic test_wrap();
    host_op(1, 0, 1, 8'hFF);
    host_op(1, 0, 1, 8'h7F);
    host_op(1, 0, 0, 8'h11);
    chk_cnt++; if ({vram_we, vram_addr} !== {1'b1, 14'h3FFF}) $display("FAIL wrap_top: we=%b addr=%h want 1 3fff", vram_we, vram_addr); else pass_cnt++;
    step();
    chk_cnt++; if (vram_addr !== 14'h0000) $display("FAIL wrap_addr: got %h want 0000", vram_addr); else pass_cnt++;
    host_op(1, 0, 0, 8'h22);
    chk_cnt++; if ({vram_we, vram_addr} !== {1'b1, 14'h0000}) $display("FAIL wrap_next_write: we=%b addr=%h want 1 0000", vram_we, vram_addr); else pass_cnt++;
    step();
    chk_cnt++; if ({mem[14'h3FFF], mem[14'h0000]} !== 16'h1122) $display("FAIL wrap_mem: got %h want 1122", {mem[14'h3FFF], mem[14'h0000]}); else pass_cnt++;
  endtask

  task automatic test_status();
    host_op(1, 0, 1, 8'h12);
    status_in = 8'h9F;
    host_op(0, 1, 1, 8'h00);
    chk_cnt++; if ({cpu_bus.cpu_dout, status_clr, cpu_bus.cpu_busy} !== {8'h9F, 1'b1, 1'b0}) $display("FAIL status_read: dout=%h clr=%b busy=%b want 9f 1 0", cpu_bus.cpu_dout, status_clr, cpu_bus.cpu_busy); else pass_cnt++;
    step();
    chk_cnt++; if (status_clr !== 1'b0) $display("FAIL status_oneshot: clr=%b want 0", status_clr); else pass_cnt++;
    host_op(1, 0, 1, 8'h00);
    host_op(1, 0, 1, 8'h40);
    chk_cnt++; if ({vram_addr, cpu_bus.cpu_busy} !== {14'h0000, 1'b0}) $display("FAIL status_phase_clr: addr=%h busy=%b want 0000 0", vram_addr, cpu_bus.cpu_busy); else pass_cnt++;
  endtask

  task automatic test_wr_rd_same();
    status_in = 8'hC3;
    host_op(1, 1, 1, 8'h55);
    chk_cnt++; if ({status_clr, cpu_bus.cpu_dout} !== {1'b0, 8'h9F}) $display("FAIL wr_wins_rd: clr=%b dout=%h want 0 9f", status_clr, cpu_bus.cpu_dout); else pass_cnt++;
    host_op(1, 0, 1, 8'h40);
    chk_cnt++; if (vram_addr !== 14'h0055) $display("FAIL wr_wins_addr: got %h want 0055", vram_addr); else pass_cnt++;
  endtask

  task automatic test_busy_drop();
    host_op(1, 0, 1, 8'h00);
    host_op(1, 0, 1, 8'h01);
    host_op(0, 1, 0, 8'h00);
    step();
    chk_cnt++; if ({cpu_bus.cpu_busy, vram_addr, cpu_bus.cpu_dout} !== {1'b0, 14'h0101, 8'h9F}) $display("FAIL busy_drop: busy=%b addr=%h dout=%h want 0 0101 9f", cpu_bus.cpu_busy, vram_addr, cpu_bus.cpu_dout); else pass_cnt++;
    step();
    chk_cnt++; if ({cpu_bus.cpu_busy, vram_addr} !== {1'b0, 14'h0101}) $display("FAIL busy_drop_idle: busy=%b addr=%h want 0 0101", cpu_bus.cpu_busy, vram_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    host_op(1, 0, 0, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({vram_we, vram_addr, cpu_bus.cpu_busy} !== {1'b0, 14'h0000, 1'b0}) $display("FAIL rst_in_write: we=%b addr=%h busy=%b want 0 0000 0", vram_we, vram_addr, cpu_bus.cpu_busy); else pass_cnt++;
    step(); rst_n = 1'b1; step();
    host_op(1, 0, 1, 8'h00);
    host_op(1, 0, 1, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({cpu_bus.cpu_busy, vram_addr, vram_we, cpu_bus.cpu_dout} !== {1'b0, 14'h0000, 1'b0, 8'h00}) $display("FAIL rst_in_fetch: busy=%b addr=%h we=%b dout=%h want 0 0000 0 00", cpu_bus.cpu_busy, vram_addr, vram_we, cpu_bus.cpu_dout); else pass_cnt++;
    chk_cnt++; if ({reg_we, reg_num, reg_data, status_clr, vram_din} !== 21'h0) $display("FAIL rst_in_fetch_regs: we=%b num=%h data=%h clr=%b din=%h want 0", reg_we, reg_num, reg_data, status_clr, vram_din); else pass_cnt++;
    step(); step();
    chk_cnt++; if ({cpu_bus.cpu_busy, vram_addr} !== {1'b0, 14'h0000}) $display("FAIL rst_held: busy=%b addr=%h want 0 0000", cpu_bus.cpu_busy, vram_addr); else pass_cnt++;
    rst_n = 1'b1; step();
  endtask

  task automatic test_write_readahead();
    logic [7:0] exp_dout;
`ifdef VDP_WRITE_READAHEAD_EN
    exp_dout = 8'h66;
`else
    exp_dout = 8'h00;
`endif
    host_op(1, 0, 0, 8'h66); step();
    chk_cnt++; if (vram_addr !== 14'h0001) $display("FAIL ra_write_addr: got %h want 0001", vram_addr); else pass_cnt++;
    host_op(0, 1, 0, 8'h00);
    chk_cnt++; if (cpu_bus.cpu_dout !== exp_dout) $display("FAIL ra_read_dout: got %h want %h", cpu_bus.cpu_dout, exp_dout); else pass_cnt++;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_reg_write();
    test_read();
    test_wrap();
    test_status();
    test_wr_rd_same();
    test_busy_drop();
    test_reset_mid();
    test_write_readahead();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-side host interface of the VDP: decodes the two-port (mode 0 data / mode 1 control) byte protocol and turns it into writes and read-ahead fetches on the write/read port of the 16 KB VRAM, plus register writes and status reads. It is the initiator for the VRAM's single-cycle-latency synchronous port. The display fetch engine owns the VRAM's second port. This block sits between the host bus synchronizer and the VRAM.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width (16 KB)
- DATA_W, 8, data byte width

Ports:
- clk  in  1  system clock; one clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cpu_wr  in  1  one-cycle host write strobe
- cpu_rd  in  1  one-cycle host read strobe
- cpu_mode  in  1  0 = data port, 1 = control port
- cpu_din  in  8  host write byte
- cpu_dout  out  8  registered host read byte
- cpu_busy  out  1  high while a VRAM access is in progress
- vram_addr  out  14  VRAM port address
- vram_we  out  1  VRAM write enable
- vram_din  out  8  VRAM write data
- vram_dout  in  8  VRAM read data; valid one clock after the address is sampled
- reg_we  out  1  one-cycle register write pulse
- reg_num  out  3  register index
- reg_data  out  8  register value
- status_in  in  8  status byte from the display engine
- status_clr  out  1  one-cycle pulse after a status read

## Operation
- State held: addr (14 b), latch_lo (8 b), second-byte flag `phase`, read-ahead buffer `rab` (8 b), and an FSM with states IDLE, WRITE, FETCH, CAPTURE.
- Control write, phase=0: latch_lo <= cpu_din; phase <= 1.
- Control write, phase=1: phase <= 0.
  - If cpu_din[7]=1: register write. reg_num <= cpu_din[2:0], reg_data <= latch_lo, reg_we pulses.
  - Else addr <= {cpu_din[5:0], latch_lo}.
  - If cpu_din[7:6]=00 (read setup): go to FETCH.
  - If cpu_din[7:6]=01 (write setup): address only.
- Control read: cpu_dout <= status_in; phase <= 0; status_clr pulses.
- Data write: phase <= 0; go to WRITE. In WRITE, vram_addr=addr, vram_din=byte, vram_we=1; addr increments; return to IDLE.
- Data read: phase <= 0; cpu_dout <= rab; go to FETCH.
- FETCH: vram_addr=addr; go to CAPTURE.
- CAPTURE: rab <= vram_dout; addr increments; return to IDLE.
- addr increment wraps 0x3FFF -> 0x0000.
- Strobes are accepted only in IDLE. A strobe while cpu_busy=1 is dropped and has no effect. cpu_wr and cpu_rd in the same cycle: cpu_wr wins and cpu_rd is dropped.
- Reset values: addr 0, latch_lo 0, phase 0, rab 0x00, cpu_dout 0x00, vram_we 0, vram_din 0, vram_addr 0, reg_we 0, reg_num 0, reg_data 0, status_clr 0, cpu_busy 0, FSM IDLE.
- Reset asserted mid-access aborts immediately: vram_we drops asynchronously, and there is no partial increment.

## Timing
- Strobe in cycle N; all state updates registered at the end of cycle N.
- Write: vram_we high during cycle N+1 only; cpu_busy high in N+1.
- Read / read setup: FETCH in N+1, CAPTURE in N+2; rab valid from N+3; cpu_busy high in N+1..N+2. The next strobe is accepted in N+3.
- cpu_dout updates at the end of cycle N and holds until the next read.
- reg_we and status_clr are high during cycle N+1 for exactly one cycle.
- vram_addr is driven combinationally from the FSM and addr; it holds addr in IDLE.

## Configuration
- VDP_WRITE_READAHEAD_EN defined: a data write also loads rab <= cpu_din in the WRITE cycle. This is the legacy chip behaviour, where a read after a write returns the written byte.
- Undefined: data writes leave rab untouched.

## Structure
- Shared package `vdp_pkg`:
  - FSM state enum (IDLE/WRITE/FETCH/CAPTURE)
  - VRAM_ADDR_W=14, VRAM_ADDR_MAX=14'h3FFF
  - control-byte field constants: CTL_REG_BIT=7, CTL_WRITE_BIT=6
- No sub-module; the single flat block is 150-250 lines.

## Test plan
- Reset, then control 0x34, 0x52 -> addr=0x1234, no FETCH; data write 0xA5 -> vram_we one cycle at 0x1234 with din 0xA5, addr=0x1235.
- Control 0x07, 0x81 -> reg_we one cycle, reg_num=1, reg_data=0x07, addr unchanged.
- Preload VRAM[0x0100]=0x3C, [0x0101]=0x5A; control 0x00, 0x01 -> rab=0x3C at N+3. Data read -> cpu_dout=0x3C, then rab=0x5A, addr=0x0102.
- Set addr 0x3FFF (control 0xFF, 0x7F); data write -> next write lands at 0x0000.
- Control write 0x12, then control read with status_in=0x9F -> cpu_dout=0x9F, status_clr pulses, phase cleared. The following control 0x00, 0x40 sets addr=0x0000.
- Data read strobe while busy is dropped. rst_n low during FETCH -> all outputs at reset values. With VDP_WRITE_READAHEAD_EN, write 0x66 then data read -> cpu_dout=0x66.
